// File: rtl/ntt_mult_red_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared fixed-latency multiply-reduce unit
// and routes each reduced result back to its issuer through a {valid, id, tag} pipeline.
module ntt_mult_red_arbiter #(
   parameter int REG_SIZE    = 23,
   parameter int NUM_REQ     = 2,
   parameter int TAG_W       = 8,
   parameter int RED_LATENCY = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            zeroize,
   input  logic                            fixed_prio_i,
   input  logic                            drain_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   input  logic [NUM_REQ*2*REG_SIZE-1:0]   req_opa_i,
   input  logic [NUM_REQ*TAG_W-1:0]        req_tag_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   output logic [2*REG_SIZE-1:0]           red_opa_o,
   input  logic [REG_SIZE-1:0]             red_res_i,
   output logic [NUM_REQ-1:0]              rsp_valid_o,
   output logic [REG_SIZE-1:0]             rsp_res_o,
   output logic [TAG_W-1:0]                rsp_tag_o,
   output logic                            busy_o,
   output logic                            drain_done_o
);

   localparam int OPA_W = 2 * REG_SIZE;
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int LAST  = RED_LATENCY - 1;
   localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

   logic [ID_W-1:0]        ptr_q, ptr_d;
   logic [RED_LATENCY-1:0] vld_q, vld_d;
   logic [ID_W-1:0]        id_q  [RED_LATENCY];
   logic [ID_W-1:0]        id_d  [RED_LATENCY];
   logic [TAG_W-1:0]       tag_q [RED_LATENCY];
   logic [TAG_W-1:0]       tag_d [RED_LATENCY];

   logic [NUM_REQ-1:0] elig;
   logic [ID_W:0]      pick_res;
   logic               gnt_vld;
   logic [ID_W-1:0]    gnt_id;
   logic [NUM_REQ-1:0] gnt_oh;
   logic [OPA_W-1:0]   gnt_opa;
   logic [TAG_W-1:0]   gnt_tag;
   logic               live;
   logic               rsp_fire;

   // First pass takes the first eligible index above the pointer (or the lowest
   // in fixed mode); the second pass supplies the round-robin wrap.
   function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] el,
                                          input logic [ID_W-1:0]    ptr,
                                          input logic               fixed);
      logic            found;
      logic [ID_W-1:0] id;
      found = 1'b0;
      id    = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && el[j] && (fixed || (j > int'(ptr)))) begin
            found = 1'b1;
            id    = ID_W'(j);
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && el[j]) begin
            found = 1'b1;
            id    = ID_W'(j);
         end
      end
      return {found, id};
   endfunction

   assign live = reset_n & ~zeroize;

   always_comb begin
      elig     = (drain_i | zeroize) ? '0 : req_valid_i;
      pick_res = pick(elig, ptr_q, fixed_prio_i);
      gnt_vld  = pick_res[ID_W];
      gnt_id   = pick_res[ID_W-1:0];
      gnt_oh   = '0;
      gnt_opa  = '0;
      gnt_tag  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (gnt_vld && (gnt_id == ID_W'(j))) begin
            gnt_oh[j] = 1'b1;
            gnt_opa   = req_opa_i[j*OPA_W +: OPA_W];
            gnt_tag   = req_tag_i[j*TAG_W +: TAG_W];
         end
      end
   end

   // Grant stage: operand goes straight to the reducer, tracking enters stage 0.
   assign req_ready_o = reset_n ? gnt_oh  : '0;
   assign red_opa_o   = reset_n ? gnt_opa : '0;

   always_comb begin
      ptr_d = ptr_q;
      vld_d = '0;
      for (int i = 0; i < RED_LATENCY; i++) begin
         id_d[i]  = '0;
         tag_d[i] = '0;
      end
      if (zeroize) begin
         ptr_d = PTR_RST;
      end else begin
         if (gnt_vld) begin
            ptr_d = gnt_id;
         end
         vld_d[0] = gnt_vld;
         id_d[0]  = gnt_id;
         tag_d[0] = gnt_tag;
         for (int i = 1; i < RED_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
            tag_d[i] = tag_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= PTR_RST;
         vld_q <= '0;
         for (int i = 0; i < RED_LATENCY; i++) begin
            id_q[i]  <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         vld_q <= vld_d;
         for (int i = 0; i < RED_LATENCY; i++) begin
            id_q[i]  <= id_d[i];
            tag_q[i] <= tag_d[i];
         end
      end
   end

   // Response stage: last tracking entry lines up with the reducer output.
   assign rsp_fire = live & vld_q[LAST];

   always_comb begin
      rsp_valid_o = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (rsp_fire && (id_q[LAST] == ID_W'(j))) begin
            rsp_valid_o[j] = 1'b1;
         end
      end
   end

   assign rsp_tag_o    = rsp_fire ? tag_q[LAST] : '0;
   assign rsp_res_o    = red_res_i;
   assign busy_o       = live & ((|req_valid_i) | (|vld_q));
   assign drain_done_o = live & drain_i & ~(|vld_q);

endmodule

// File: doc/ntt_mult_red_arbiter.md
Name: ntt_mult_red_arbiter

Overview:
Shares one fixed-latency, fully pipelined MLDSA multiplier-reduction unit between NUM_REQ requesters, for example butterfly lanes and the pointwise-multiply engine. Each cycle it grants at most one requester, using round-robin or fixed priority. It drives the granted 46-bit product to the reduction unit and carries a valid/ID/tag pipeline alongside it. When a reduced result emerges it is routed back to the requester that issued it. A drain control lets the top-level scheduler quiesce the shared unit before a mode switch.

Parameters:
REG_SIZE, 23, coefficient width; the product is 2*REG_SIZE bits.
NUM_REQ, 2, number of requesters; legal range 2..4.
TAG_W, 8, width of the opaque tag returned with each result.
RED_LATENCY, 4, clock edges from red_opa_o presented to the matching red_res_i valid; must equal the latency of the reduction unit; minimum 1.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
zeroize  input  1  synchronous clear of all state
fixed_prio_i  input  1  1 = fixed priority (lowest index wins); 0 = round-robin
drain_i  input  1  1 = block new grants
req_valid_i  input  NUM_REQ  per-requester request valid
req_opa_i  input  NUM_REQ*2*REG_SIZE  per-requester product; requester i uses slice i
req_tag_i  input  NUM_REQ*TAG_W  per-requester tag
req_ready_o  output  NUM_REQ  one-hot grant; handshake = valid & ready
red_opa_o  output  2*REG_SIZE  operand to the reduction unit
red_res_i  input  REG_SIZE  result from the reduction unit
rsp_valid_o  output  NUM_REQ  one-hot result valid for the owning requester
rsp_res_o  output  REG_SIZE  reduced result; equals red_res_i
rsp_tag_o  output  TAG_W  tag of the returning result
busy_o  output  1  any request pending or any operation in flight
drain_done_o  output  1  drain_i=1 and pipeline empty

Behaviour:
- Reset/zeroize values: RR pointer = NUM_REQ-1 (so requester 0 wins first); pipeline valid bits = 0; IDs and tags = 0.
- Output values while reset or zeroize is active: rsp_valid_o=0, req_ready_o=0, busy_o=0, drain_done_o=0.
- Zeroize has priority over all other activity. Zeroize mid-flight drops every in-flight result; no rsp_valid_o fires for it afterwards.
- Arbitration (combinational) in cycle t: eligible set = req_valid_i, or empty when drain_i|zeroize.
  - Round-robin: grant the first eligible index after the RR pointer, scanning upward with wrap.
  - Fixed priority: grant the lowest eligible index.
- req_ready_o is one-hot or zero and is asserted only to a valid requester.
- Requester obligations: keep valid, opa and tag stable until handshake; no backpressure exists on results.
- RR pointer updates to the granted index at the edge ending a grant cycle, in both modes. It holds when nothing is granted.
- Switching fixed_prio_i takes effect in the same cycle and does not reset the pointer.
- red_opa_o = granted requester's req_opa_i slice (combinational), or 0 when there is no grant. An idle reducer therefore sees zero operands, which reduce to 0.
- Tracking pipeline: RED_LATENCY stages of {valid, id[$clog2(NUM_REQ)], tag}. Stage 0 loads {grant, id, tag} at the edge ending cycle t. Each stage shifts every cycle.
- Response: the last stage drives rsp_valid_o[id] and rsp_tag_o. A handshake in cycle t produces its response in cycle t+RED_LATENCY, with rsp_res_o=red_res_i.
  - rsp_tag_o = 0 when the last stage is invalid.
  - Throughput: 1 result/cycle; back-to-back grants produce back-to-back responses, in order.
- busy_o = |req_valid_i | any stage valid.
- drain_done_o = drain_i & no stage valid. Asserting drain_i mid-burst stops grants in the same cycle. In-flight results still return, and drain_done_o rises in the cycle after the last stage clears.
- A request raised in the same cycle drain_i falls is grantable in that cycle.

Test Plan:
- Single op: req0 valid, opa=46'd8380418 (q+1), tag=8'h5A, real reducer attached -> req_ready_o=01 that cycle; 4 cycles later rsp_valid_o=01, rsp_res_o=1, rsp_tag_o=5A; nothing else fires.
- Round-robin: req0 and req1 both held valid for 6 cycles -> grants 0,1,0,1,0,1; responses alternate with matching tags, each 4 cycles after its grant.
- Fixed priority: fixed_prio_i=1, both valid for 3 cycles -> req0 granted every cycle; req1 starves. Then req0 drops -> req1 granted next cycle.
- Drain: 3 back-to-back grants, then drain_i=1 with both still valid -> no further req_ready_o; 3 responses arrive; drain_done_o=1 in the cycle after the last response; busy_o stays 1 while valids are held.
- Zeroize mid-flight: 2 ops in flight, zeroize pulsed 1 cycle -> no rsp_valid_o for either op; RR pointer reset so req0 wins the next contended grant.
- Async reset: reset_n low mid-burst -> all outputs 0 immediately. After release, the first grant goes to req0 and red_opa_o=0 while idle.
